// File: rtl/difftest_pkg.sv
// ---------------------------------------------------------------------------
// difftest_pkg
//   Shared types and sizes for the difftest commit-side collector.
//   XLEN / NR_REGS   : architectural register width and count.
//   commit_entry_t   : one retired-instruction record as queued in the FIFO.
//   ENTRY_W          : packed width of commit_entry_t.
// ---------------------------------------------------------------------------
package difftest_pkg;

  localparam int XLEN    = 64;
  localparam int NR_REGS = 32;
  localparam int REG_AW  = $clog2(NR_REGS);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [31:0]       inst;
    logic              wen;
    logic [REG_AW-1:0] waddr;
    logic [XLEN-1:0]   wdata;
    logic              skip;
  } commit_entry_t;

  localparam int ENTRY_W = $bits(commit_entry_t);

endpackage

// File: rtl/difftest_fifo.sv
// ---------------------------------------------------------------------------
// difftest_fifo
//   Generic single-clock FIFO with first-word-fall-through read: the head
//   entry is visible on pop_data whenever empty is low.
//   Ports:
//     clock      in   clock, all state updates on posedge
//     reset      in   synchronous active-low reset (clears the pointers)
//     push       in   write push_data (ignored while full)
//     push_data  in   WIDTH-bit entry
//     pop        in   drop the head entry (ignored while empty)
//     pop_data   out  head entry
//     full       out  no free slot
//     empty      out  no entry held
// ---------------------------------------------------------------------------
module difftest_fifo
  import difftest_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit tells a full buffer apart from an empty one.
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage needs no reset: slots are only read after being written.
  always_ff @(posedge clock) begin
    if (do_push) mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign pop_data = mem_reg[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/difftest_commit_buffer.sv
// ---------------------------------------------------------------------------
// difftest_commit_buffer
//   Queues retired-instruction records, replays them one per handshake into
//   a 32x64 shadow register file and presents the resulting snapshot together
//   with the commit that produced it. Also counts presented commits and
//   raises a sticky flag when no commit has been accepted for TIMEOUT cycles.
//   Ports:
//     clock, reset                  clock; synchronous active-low reset
//     cmt_valid / cmt_ready         retire record handshake (ready = !full)
//     cmt_pc/inst/wen/waddr/wdata/skip  retire record fields
//     out_valid / out_ready         presented-commit handshake
//     out_pc/out_inst/out_skip      presented commit info
//     regs_data                     packed shadow regs, reg i at [i*64 +: 64]
//     commit_count                  commits presented since reset (wraps)
//     stall_timeout                 sticky commit-stall flag
// ---------------------------------------------------------------------------
module difftest_commit_buffer
  import difftest_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmt_valid,
  output logic                      cmt_ready,
  input  logic [XLEN-1:0]           cmt_pc,
  input  logic [31:0]               cmt_inst,
  input  logic                      cmt_wen,
  input  logic [REG_AW-1:0]         cmt_waddr,
  input  logic [XLEN-1:0]           cmt_wdata,
  input  logic                      cmt_skip,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [31:0]               out_inst,
  output logic                      out_skip,
  output logic [XLEN*NR_REGS-1:0]   regs_data,
  output logic [63:0]               commit_count,
  output logic                      stall_timeout
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

  commit_entry_t      in_entry;
  commit_entry_t      head_entry;
  logic [ENTRY_W-1:0] head_bits;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  logic               out_valid_reg;
  logic [XLEN-1:0]    out_pc_reg;
  logic [31:0]        out_inst_reg;
  logic               out_skip_reg;
  logic [XLEN-1:0]    shadow_reg [NR_REGS];
  logic [63:0]        commit_count_reg;
  logic [IDLE_W-1:0]  idle_reg;
  logic [IDLE_W-1:0]  idle_next;
  logic               stall_reg;

  always_comb begin
    in_entry       = '0;
    in_entry.pc    = cmt_pc;
    in_entry.inst  = cmt_inst;
    in_entry.wen   = cmt_wen;
    in_entry.waddr = cmt_waddr;
    in_entry.wdata = cmt_wdata;
    in_entry.skip  = cmt_skip;
  end

  assign head_entry = commit_entry_t'(head_bits);
  assign cmt_ready  = !fifo_full;
  assign push       = cmt_valid && !fifo_full;
  // Advance whenever the output register is free or is being consumed.
  assign pop        = !fifo_empty && (!out_valid_reg || out_ready);

  difftest_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (in_entry),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Output stage: the shadow write lands on the same edge that presents the
  // commit, so regs_data already reflects it while out_valid is high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_reg    <= 1'b0;
      out_pc_reg       <= '0;
      out_inst_reg     <= '0;
      out_skip_reg     <= 1'b0;
      commit_count_reg <= '0;
      for (int i = 0; i < NR_REGS; i++) shadow_reg[i] <= '0;
    end else if (pop) begin
      out_valid_reg    <= 1'b1;
      out_pc_reg       <= head_entry.pc;
      out_inst_reg     <= head_entry.inst;
      out_skip_reg     <= head_entry.skip;
      commit_count_reg <= commit_count_reg + 64'd1;
      // x0 is hardwired to zero: its slot is only ever written by reset.
      if (head_entry.wen && (head_entry.waddr != '0))
        shadow_reg[head_entry.waddr] <= head_entry.wdata;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Watchdog: counts cycles since the last accepted push, saturating.
  always_comb begin
    idle_next = idle_reg;
    if (push)
      idle_next = '0;
    else if (idle_reg != IDLE_MAX)
      idle_next = idle_reg + IDLE_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      idle_reg  <= '0;
      stall_reg <= 1'b0;
    end else begin
      idle_reg <= idle_next;
      if (idle_next == IDLE_MAX) stall_reg <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NR_REGS; gi++) begin : g_regs
      assign regs_data[gi*XLEN +: XLEN] = shadow_reg[gi];
    end
  endgenerate

  assign out_valid     = out_valid_reg;
  assign out_pc        = out_pc_reg;
  assign out_inst      = out_inst_reg;
  assign out_skip      = out_skip_reg;
  assign commit_count  = commit_count_reg;
  assign stall_timeout = stall_reg;

endmodule

// File: tb/tb_difftest_commit_buffer.sv
// ---------------------------------------------------------------------------
// tb_difftest_commit_buffer
//   Randomized and directed stimulus for difftest_commit_buffer, checked
//   against a queue-based reference model of the commit path.
// ---------------------------------------------------------------------------
module tb_difftest_commit_buffer;
  import difftest_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic                    cmt_valid = 1'b0;
  logic                    cmt_ready;
  logic [63:0]             cmt_pc = '0;
  logic [31:0]             cmt_inst = '0;
  logic                    cmt_wen = 1'b0;
  logic [4:0]              cmt_waddr = '0;
  logic [63:0]             cmt_wdata = '0;
  logic                    cmt_skip = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [63:0]             out_pc;
  logic [31:0]             out_inst;
  logic                    out_skip;
  logic [2047:0]           regs_data;
  logic [63:0]             commit_count;
  logic                    stall_timeout;

  always #5 clock = ~clock;

  difftest_commit_buffer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cmt_valid     (cmt_valid),
    .cmt_ready     (cmt_ready),
    .cmt_pc        (cmt_pc),
    .cmt_inst      (cmt_inst),
    .cmt_wen       (cmt_wen),
    .cmt_waddr     (cmt_waddr),
    .cmt_wdata     (cmt_wdata),
    .cmt_skip      (cmt_skip),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_skip      (out_skip),
    .regs_data     (regs_data),
    .commit_count  (commit_count),
    .stall_timeout (stall_timeout)
  );

  // Reference model state
  commit_entry_t q[$];
  logic          m_ov;
  logic [63:0]   m_pc;
  logic [31:0]   m_inst;
  logic          m_skip;
  logic [63:0]   m_regs [32];
  logic [63:0]   m_cnt;
  int            m_idle;
  logic          m_stall;
  logic          last_push;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic commit_entry_t cur_rec();
    commit_entry_t r;
    r.pc = cmt_pc; r.inst = cmt_inst; r.wen = cmt_wen;
    r.waddr = cmt_waddr; r.wdata = cmt_wdata; r.skip = cmt_skip;
    return r;
  endfunction

  function automatic commit_entry_t rand_rec();
    commit_entry_t r;
    r.pc    = {$urandom, $urandom};
    r.inst  = $urandom;
    r.wen   = 1'($urandom_range(0, 3) != 0);
    r.waddr = 5'($urandom_range(0, 31));
    r.wdata = {$urandom, $urandom};
    r.skip  = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic drive(input commit_entry_t r);
    cmt_pc = r.pc; cmt_inst = r.inst; cmt_wen = r.wen;
    cmt_waddr = r.waddr; cmt_wdata = r.wdata; cmt_skip = r.skip;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    commit_entry_t e;
    bit p_push, p_pop;
    if (reset == 1'b0) begin
      q.delete();
      m_ov = 1'b0; m_pc = '0; m_inst = '0; m_skip = 1'b0;
      foreach (m_regs[i]) m_regs[i] = '0;
      m_cnt = '0; m_idle = 0; m_stall = 1'b0; last_push = 1'b0;
    end else begin
      p_push = cmt_valid && (q.size() < DEPTH);
      p_pop  = (q.size() != 0) && (!m_ov || out_ready);
      if (p_pop) begin
        e = q.pop_front();
        m_ov = 1'b1; m_pc = e.pc; m_inst = e.inst; m_skip = e.skip;
        if (e.wen && e.waddr != 5'd0) m_regs[e.waddr] = e.wdata;
        m_cnt = m_cnt + 64'd1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (p_push) q.push_back(cur_rec());
      if (p_push) m_idle = 0;
      else if (m_idle < TIMEOUT) m_idle++;
      if (m_idle == TIMEOUT) m_stall = 1'b1;
      last_push = p_push;
    end
  endtask

  task automatic compare_all();
    check("cmt_ready", 64'(cmt_ready), 64'(q.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("out_pc", out_pc, m_pc);
    check("out_inst", 64'(out_inst), 64'(m_inst));
    check("out_skip", 64'(out_skip), 64'(m_skip));
    check("commit_count", commit_count, m_cnt);
    check("stall_timeout", 64'(stall_timeout), 64'(m_stall));
    for (int i = 0; i < 32; i++)
      check($sformatf("x%0d", i), regs_data[i*64 +: 64], m_regs[i]);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  // Hold a record on the input until the model says it was accepted.
  task automatic push_rec(input commit_entry_t r);
    bit done;
    done = 1'b0;
    drive(r);
    cmt_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      done = last_push;
    end
    if (!done) check("push_accept_timeout", 64'd0, 64'd1);
    cmt_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cmt_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    commit_entry_t r;
    #1;
    do_reset();

    // 1: single commit writes x5
    out_ready = 1'b1;
    r = '0; r.pc = 64'h8000_0000; r.inst = 32'h0000_0013; r.wen = 1'b1;
    r.waddr = 5'd5; r.wdata = 64'hDEAD;
    push_rec(r);
    check("t1_no_bypass", 64'(out_valid), 64'd0);
    tick();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_x5", regs_data[383:320], 64'hDEAD);
    check("t1_count", commit_count, 64'd1);
    tick();
    check("t1_valid_drop", 64'(out_valid), 64'd0);

    // 2: write to x0 is dropped
    r = '0; r.pc = 64'h8000_0004; r.wen = 1'b1; r.waddr = 5'd0; r.wdata = 64'h1234;
    push_rec(r);
    tick();
    check("t2_valid", 64'(out_valid), 64'd1);
    check("t2_x0", regs_data[63:0], 64'd0);
    tick();
    check("t2_valid_drop", 64'(out_valid), 64'd0);

    // 3: back-pressure fills output reg plus FIFO, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_rec(rand_rec());
    check("t3_ready_low", 64'(cmt_ready), 64'd0);
    drive(rand_rec());
    cmt_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    cmt_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("t3_count", commit_count, 64'd7);

    // 4: full FIFO, continuous push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_rec(rand_rec());
    out_ready = 1'b1;
    drive(rand_rec());
    cmt_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (last_push) drive(rand_rec());
    end
    cmt_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Random phase with occasional mid-stream reset
    drive(rand_rec());
    for (int i = 0; i < 250; i++) begin
      if (!cmt_valid || last_push) begin
        drive(rand_rec());
        cmt_valid = 1'($urandom_range(0, 2) != 0);
      end
      out_ready = 1'($urandom_range(0, 2) != 0);
      reset = 1'($urandom_range(0, 79) != 0);
      tick();
      reset = 1'b1;
    end
    cmt_valid = 1'b0;

    // 5: watchdog
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("t5_stall_before", 64'(stall_timeout), 64'd0);
    tick();
    check("t5_stall_set", 64'(stall_timeout), 64'd1);
    push_rec(rand_rec());
    tick();
    tick();
    check("t5_stall_sticky", 64'(stall_timeout), 64'd1);
    do_reset();
    check("t5_stall_cleared", 64'(stall_timeout), 64'd0);

    // 6: reset with three entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_rec(rand_rec());
    check("t6_queued", 64'(q.size()), 64'd3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_count", commit_count, 64'd0);
    check("t6_ready", 64'(cmt_ready), 64'd1);
    check("t6_regs_zero", 64'(regs_data == '0), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("t6_discarded", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
